// File: rtl/fp32_pkg.sv
// Shared fp32 constants, multiplier FSM encoding and operand classification
// used by the single-precision multiplier.
package fp32_pkg;

    localparam logic [31:0] FP32_QNAN  = 32'h7FC0_0000;
    localparam int          FP32_BIAS  = 127;
    localparam int          EXP_W      = 8;
    localparam int          MAN_W      = 23;
    localparam int          MUL_CYCLES = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_MUL    = 3'd2,
        ST_ROUND  = 3'd3,
        ST_DONE   = 3'd4
    } mul_state_e;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    // Denormals (exp==0) are flushed and therefore classified as zero.
    function automatic fp_class_t fp_classify(input logic [31:0] v);
        fp_class_t c;
        c.zero = (v[30:23] == 8'h00);
        c.inf  = (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
        c.nan  = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
        return c;
    endfunction

endpackage

// File: rtl/multi_unit_if.sv
// Trigger/operand/result bundle between the Multi controller and multi_unit.
interface multi_unit_if;

    logic        mul_trig_in;
    logic [31:0] mul_data1_in;
    logic [31:0] mul_data2_in;
    logic [31:0] mul_result_out;
    logic        mul_result_vld;
    logic        busy;

    modport master (
        output mul_trig_in, mul_data1_in, mul_data2_in,
        input  mul_result_out, mul_result_vld, busy
    );

    modport slave (
        input  mul_trig_in, mul_data1_in, mul_data2_in,
        output mul_result_out, mul_result_vld, busy
    );

endinterface

// File: rtl/mant_mul_seq.sv
// 24x24 sequential shift-add mantissa multiplier; one partial product per cycle.
// done is high during the final accumulation cycle, so product is complete after that edge.
module mant_mul_seq
    import fp32_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [MAN_W:0]         a,
    input  logic [MAN_W:0]         b,
    output logic [2*MAN_W+1:0]     product,
    output logic                   done
);

    localparam logic [4:0] LAST_CNT = 5'(MUL_CYCLES - 1);

    logic [47:0] acc_q, acc_d;
    logic [47:0] addend_q, addend_d;
    logic [23:0] mplr_q, mplr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        run_q, run_d;

    // Next-state for the shift-add datapath.
    always_comb begin
        acc_d    = acc_q;
        addend_d = addend_q;
        mplr_d   = mplr_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            acc_d    = 48'd0;
            addend_d = {24'd0, a};
            mplr_d   = b;
            cnt_d    = 5'd0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplr_q[0]) begin
                acc_d = acc_q + addend_q;
            end else begin
                acc_d = acc_q;
            end
            addend_d = addend_q << 1;
            mplr_d   = mplr_q >> 1;
            if (cnt_q == LAST_CNT) begin
                cnt_d = 5'd0;
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 5'd1;
                run_d = 1'b1;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= 48'd0;
            addend_q <= 48'd0;
            mplr_q   <= 24'd0;
            cnt_q    <= 5'd0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            addend_q <= addend_d;
            mplr_q   <= mplr_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    assign product = acc_q;
    assign done    = run_q && (cnt_q == LAST_CNT);

endmodule

// File: rtl/multi_unit.sv
// IEEE-754 single-precision multiplier: operand latch, classification,
// sequential mantissa multiply and round-to-nearest-even with fixed 27-cycle latency.
module multi_unit
    import fp32_pkg::*;
(
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    multi_unit_if.slave  bus
);

    mul_state_e        state_q, state_d;
    logic [31:0]       opa_q, opa_d, opb_q, opb_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    fp_class_t         cls_a_q, cls_a_d, cls_b_q, cls_b_d;
    logic [31:0]       result_q, result_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;

    logic              mul_start_s;
    logic              mul_done_s;
    logic [47:0]       product_s;

    logic [23:0]       kept_s;
    logic              guard_s, sticky_s, inc_s;
    logic [24:0]       sum_s;
    logic [22:0]       frac_s;
    logic signed [9:0] exp_norm_s, exp_fin_s;
    logic [31:0]       round_s;

    mant_mul_seq u_mant_mul (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .start   (mul_start_s),
        .a       ({1'b1, opa_q[MAN_W-1:0]}),
        .b       ({1'b1, opb_q[MAN_W-1:0]}),
        .product (product_s),
        .done    (mul_done_s)
    );

    // FSM next-state, operand capture and output staging.
    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        mul_start_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.mul_trig_in) begin
                    state_d = ST_UNPACK;
                    opa_d   = bus.mul_data1_in;
                    opb_d   = bus.mul_data2_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UNPACK: begin
                state_d     = ST_MUL;
                mul_start_s = 1'b1;
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_ROUND: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d   = (state_d == ST_UNPACK) || (state_d == ST_MUL) || (state_d == ST_ROUND);
        vld_d    = (state_q == ST_ROUND);
        if (vld_d) begin
            result_d = round_s;
        end else begin
            result_d = result_q;
        end
    end

    // Unpack: sign, biased exponent sum and operand classes.
    always_comb begin
        sign_d  = sign_q;
        exp_d   = exp_q;
        cls_a_d = cls_a_q;
        cls_b_d = cls_b_q;
        if (state_q == ST_UNPACK) begin
            sign_d  = opa_q[31] ^ opb_q[31];
            exp_d   = $signed({2'b00, opa_q[MAN_W+EXP_W-1:MAN_W]})
                    + $signed({2'b00, opb_q[MAN_W+EXP_W-1:MAN_W]})
                    - 10'(FP32_BIAS);
            cls_a_d = fp_classify(opa_q);
            cls_b_d = fp_classify(opb_q);
        end else begin
            sign_d  = sign_q;
        end
    end

    // Normalize, round to nearest-even and apply special-case priority.
    always_comb begin
        if (product_s[47]) begin
            kept_s     = product_s[47:24];
            guard_s    = product_s[23];
            sticky_s   = |product_s[22:0];
            exp_norm_s = exp_q + 10'sd1;
        end else begin
            kept_s     = product_s[46:23];
            guard_s    = product_s[22];
            sticky_s   = |product_s[21:0];
            exp_norm_s = exp_q;
        end
        inc_s = guard_s & (sticky_s | kept_s[0]);
        sum_s = {1'b0, kept_s} + {24'd0, inc_s};
        if (sum_s[24]) begin
            frac_s    = sum_s[23:1];
            exp_fin_s = exp_norm_s + 10'sd1;
        end else begin
            frac_s    = sum_s[22:0];
            exp_fin_s = exp_norm_s;
        end

        if (cls_a_q.nan || cls_b_q.nan ||
            (cls_a_q.inf && cls_b_q.zero) || (cls_b_q.inf && cls_a_q.zero)) begin
            round_s = FP32_QNAN;
        end else if (cls_a_q.inf || cls_b_q.inf) begin
            round_s = {sign_q, 8'hFF, 23'd0};
        end else if (cls_a_q.zero || cls_b_q.zero) begin
            round_s = {sign_q, 31'd0};
        end else if (exp_fin_s >= 10'sd255) begin
            round_s = {sign_q, 8'hFF, 23'd0};
        end else if (exp_fin_s <= 10'sd0) begin
            round_s = {sign_q, 31'd0};
        end else begin
            round_s = {sign_q, exp_fin_s[7:0], frac_s};
        end
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
            sign_q   <= 1'b0;
            exp_q    <= 10'sd0;
            cls_a_q  <= '0;
            cls_b_q  <= '0;
            result_q <= 32'd0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            cls_a_q  <= cls_a_d;
            cls_b_q  <= cls_b_d;
            result_q <= result_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.mul_result_out = result_q;
    assign bus.mul_result_vld = vld_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_multi_unit.sv
// Directed self-checking bench for multi_unit: arithmetic, rounding, range,
// special operands, ignored triggers, back-to-back and mid-operation reset.
module tb_multi_unit;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    multi_unit_if bus ();

    multi_unit dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Issue one trigger and observe 40 cycles; spur_k>0 raises a stray trigger with NaN-producing operands at that cycle.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input int spur_k,
                          output int lat, output int nvld, output logic [31:0] res,
                          output logic busy_ok);
        @(negedge sys_clk);
        bus.mul_trig_in  = 1'b1;
        bus.mul_data1_in = a;
        bus.mul_data2_in = b;
        @(posedge sys_clk);
        lat = 0; nvld = 0; res = 32'd0; busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge sys_clk);
            bus.mul_trig_in = (k == spur_k);
            if (k == spur_k) begin
                bus.mul_data1_in = 32'h7F80_0000;
                bus.mul_data2_in = 32'h0000_0000;
            end
            if (bus.mul_result_vld === 1'b1) begin
                nvld++;
                if (lat == 0) begin
                    lat = k;
                    res = bus.mul_result_out;
                end
            end
            if (bus.busy !== (k <= 26)) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        sys_rst_n        = 1'b0;
        bus.mul_trig_in  = 1'b0;
        bus.mul_data1_in = 32'd0;
        bus.mul_data2_in = 32'd0;
        repeat (3) @(negedge sys_clk);
        total++;
        if (bus.mul_result_out !== 32'd0 || bus.mul_result_vld !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_in: out=%h vld=%b busy=%b want 0/0/0",
                     bus.mul_result_out, bus.mul_result_vld, bus.busy);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        total++;
        if (bus.mul_result_out !== 32'd0 || bus.mul_result_vld !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_after: out=%h vld=%b busy=%b want 0/0/0",
                     bus.mul_result_out, bus.mul_result_vld, bus.busy);
        end
    endtask

    task automatic test_basic();
        int lat, nvld; logic [31:0] res; logic busy_ok;
        launch(32'h4040_0000, 32'h4000_0000, 0, lat, nvld, res, busy_ok);
        total++;
        if (res !== 32'h40C0_0000) begin
            bad++; $display("FAIL basic_res: got %h want %h", res, 32'h40C0_0000);
        end
        total++;
        if (lat !== 27) begin
            bad++; $display("FAIL basic_lat: got %0d want 27", lat);
        end
        total++;
        if (nvld !== 1) begin
            bad++; $display("FAIL basic_vld_count: got %0d want 1", nvld);
        end
        total++;
        if (busy_ok !== 1'b1) begin
            bad++; $display("FAIL basic_busy: got %b want 1", busy_ok);
        end
        total++;
        if (bus.mul_result_out !== 32'h40C0_0000) begin
            bad++; $display("FAIL basic_hold: got %h want %h", bus.mul_result_out, 32'h40C0_0000);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va [10] = '{32'h3FC0_0000, 32'hC000_0000, 32'h3F80_0001, 32'h7F00_0000,
                                 32'h0080_0000, 32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0001,
                                 32'hFF80_0000, 32'h3F80_0000};
        logic [31:0] vb [10] = '{32'h3FC0_0000, 32'h3F00_0000, 32'h3F80_0001, 32'h7F00_0000,
                                 32'h0080_0000, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000,
                                 32'h4000_0000, 32'h8000_0000};
        logic [31:0] ve [10] = '{32'h4010_0000, 32'hBF80_0000, 32'h3F80_0002, 32'h7F80_0000,
                                 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                                 32'hFF80_0000, 32'h8000_0000};
        int lat, nvld; logic [31:0] res; logic busy_ok;
        for (int i = 0; i < 10; i++) begin
            launch(va[i], vb[i], 0, lat, nvld, res, busy_ok);
            total++;
            if (res !== ve[i] || lat !== 27 || nvld !== 1) begin
                bad++;
                $display("FAIL vec%0d %h*%h: got %h lat=%0d nvld=%0d want %h lat=27 nvld=1",
                         i, va[i], vb[i], res, lat, nvld, ve[i]);
            end
        end
    endtask

    task automatic test_ignored_trigger();
        int lat, nvld; logic [31:0] res; logic busy_ok;
        launch(32'h4040_0000, 32'h4000_0000, 10, lat, nvld, res, busy_ok);
        total++;
        if (res !== 32'h40C0_0000 || lat !== 27) begin
            bad++; $display("FAIL ignored_trig_res: got %h lat=%0d want 40c00000 lat=27", res, lat);
        end
        total++;
        if (nvld !== 1) begin
            bad++; $display("FAIL ignored_trig_vld_count: got %0d want 1", nvld);
        end
    endtask

    task automatic test_back_to_back();
        int lat1 = 0, lat2 = 0, nvld = 0;
        logic [31:0] res1 = 32'd0, res2 = 32'd0;
        logic busy28 = 1'b0;
        @(negedge sys_clk);
        bus.mul_trig_in  = 1'b1;
        bus.mul_data1_in = 32'h3FC0_0000;
        bus.mul_data2_in = 32'h3FC0_0000;
        @(posedge sys_clk);
        for (int k = 1; k <= 70; k++) begin
            @(negedge sys_clk);
            bus.mul_trig_in = 1'b0;
            if (k == 28) busy28 = bus.busy;
            if (bus.mul_result_vld === 1'b1) begin
                nvld++;
                if (lat1 == 0) begin
                    lat1 = k; res1 = bus.mul_result_out;
                    bus.mul_trig_in  = 1'b1;
                    bus.mul_data1_in = 32'hC000_0000;
                    bus.mul_data2_in = 32'h3F00_0000;
                end else if (lat2 == 0) begin
                    lat2 = k; res2 = bus.mul_result_out;
                end
            end
        end
        total++;
        if (res1 !== 32'h4010_0000 || lat1 !== 27) begin
            bad++; $display("FAIL b2b_first: got %h lat=%0d want 40100000 lat=27", res1, lat1);
        end
        total++;
        if (res2 !== 32'hBF80_0000 || lat2 !== 54) begin
            bad++; $display("FAIL b2b_second: got %h lat=%0d want bf800000 lat=54", res2, lat2);
        end
        total++;
        if (nvld !== 2 || busy28 !== 1'b1) begin
            bad++; $display("FAIL b2b_ctrl: nvld=%0d busy28=%b want 2/1", nvld, busy28);
        end
    endtask

    task automatic test_reset_mid_op();
        int nv = 0; logic outs_ok = 1'b1;
        int lat, nvld; logic [31:0] res; logic busy_ok;
        @(negedge sys_clk);
        bus.mul_trig_in  = 1'b1;
        bus.mul_data1_in = 32'h4040_0000;
        bus.mul_data2_in = 32'h4000_0000;
        @(posedge sys_clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge sys_clk);
            bus.mul_trig_in = 1'b0;
            if (k == 15) sys_rst_n = 1'b0;
            if (k == 17) sys_rst_n = 1'b1;
            #1;
            if ((k == 15 || k == 16) &&
                (bus.mul_result_out !== 32'd0 || bus.mul_result_vld !== 1'b0 || bus.busy !== 1'b0))
                outs_ok = 1'b0;
            if (bus.mul_result_vld === 1'b1) nv++;
        end
        total++;
        if (nv !== 0) begin
            bad++; $display("FAIL rst_mid_no_vld: got %0d pulses want 0", nv);
        end
        total++;
        if (outs_ok !== 1'b1) begin
            bad++; $display("FAIL rst_mid_outputs: got %b want 1 (all outputs zero)", outs_ok);
        end
        launch(32'hC000_0000, 32'h3F00_0000, 0, lat, nvld, res, busy_ok);
        total++;
        if (res !== 32'hBF80_0000 || lat !== 27 || nvld !== 1) begin
            bad++; $display("FAIL rst_mid_recover: got %h lat=%0d nvld=%0d want bf800000 lat=27 nvld=1",
                            res, lat, nvld);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignored_trigger();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
